branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised branch target buffer with per-entry 2-bit saturating counters. It replaces the fixed "predict not-taken, redirect on resolve" PC selection of the 5-stage pipeline. The IF stage queries it combinationally with the current PC to choose the next fetch address. The branch-resolve stage writes outcomes back one per cycle. It also reports mispredicts, the corrected PC, and saturating performance counters.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; must be a power of two, 2..256.
- ADDR_W, 32: PC/target width.
- CNT_W, 16: width of the performance counters.
- IDX_W, log2(ENTRIES): derived, not overridable. Index = PC[IDX_W+1:2].
- TAG_W, ADDR_W-IDX_W-2: derived. Tag = PC[ADDR_W-1:IDX_W+2].

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- LookupPC  in  ADDR_W  IF-stage PC.
- PredTaken  out  1  prediction for LookupPC; combinational.
- PredTarget  out  ADDR_W  next fetch address; combinational.
- UpdateValid  in  1  resolve-stage branch/jump outcome is valid this cycle.
- UpdatePC  in  ADDR_W  PC of the resolved instruction.
- UpdateTaken  in  1  actual outcome.
- UpdateTarget  in  ADDR_W  actual taken target.
- UpdatePredTaken  in  1  prediction made for this instruction, piped from IF.
- UpdatePredTarget  in  ADDR_W  predicted address, piped from IF.
- Mispredict  out  1  combinational; qualified by UpdateValid.
- CorrectPC  out  ADDR_W  combinational redirect address.
- BranchCount  out  CNT_W  registered; saturating count of updates.
- MispredictCount  out  CNT_W  registered; saturating count of mispredicts.

## Operation
- Each entry holds: valid (1), tag (TAG_W), target (ADDR_W), ctr (2).
- Lookup (combinational):
  - hit = valid[idx] & (tag[idx] == LookupTag).
  - If hit & ctr[1]: PredTaken = 1, PredTarget = target[idx].
  - Otherwise: PredTaken = 0, PredTarget = LookupPC + 4 (mod 2^ADDR_W).
- Update (registered, when UpdateValid = 1):
  - Hit on UpdatePC:
    - ctr increments if UpdateTaken, decrements otherwise, saturating at 2'b11 and 2'b00.
    - target <= UpdateTarget only if UpdateTaken.
  - Miss and UpdateTaken: allocate (replace) the entry at idx with valid = 1, tag, target = UpdateTarget, ctr = 2'b10 (weakly taken).
  - Miss and not taken: no table change.
- Mispredict = UpdateValid & ((UpdatePredTaken != UpdateTaken) | (UpdateTaken & UpdatePredTarget != UpdateTarget)). It is forced to 0 when UpdateValid = 0.
- CorrectPC = UpdateTaken ? UpdateTarget : UpdatePC + 4. It is driven regardless of UpdateValid.
- Counters:
  - BranchCount increments on each UpdateValid.
  - MispredictCount increments on each Mispredict.
  - Both hold at 2^CNT_W-1 and do not wrap.
- LookupPC[1:0] and UpdatePC[1:0] are ignored for indexing and tagging.

## Timing
- Reset low (asynchronous, any time):
  - All valid = 0, all ctr = 2'b01, both counters = 0.
  - Outputs immediately become PredTaken = 0 and PredTarget = LookupPC + 4.
  - Target and tag contents after reset are don't-care.
- Release of reset is synchronous to Clk in the surrounding design. The first update is accepted on the first rising edge with Reset high.
- Lookup latency is 0 cycles. Update latency is 1 cycle: a lookup in the same cycle as an update to the same entry sees the old contents, and the new contents are visible from the next cycle.
- At most one update per cycle. There is no backpressure: UpdateValid is never stalled.
- Lookup and update to different indices in the same cycle are independent.
- Mispredict and CorrectPC are combinational from the update inputs. The pipeline uses them in the same cycle to flush and redirect.
- Counter increments become visible on the edge following the qualifying update.

## Test plan
- Reset behaviour: assert Reset = 0 mid-run after several allocations, then release. Lookup of a previously allocated PC 0x40 must return PredTaken = 0 and PredTarget = 0x44, and both counters must read 0.
- Allocate and train: issue an update for PC 0x40, taken, target 0x100, predicted not-taken.
  - Same cycle: Mispredict = 1 and CorrectPC = 0x100.
  - Next cycle: lookup 0x40 gives PredTaken = 1, PredTarget = 0x100, and MispredictCount = 1.
- Counter hysteresis on PC 0x40:
  - Three taken updates, then one not-taken: lookup still predicts taken (ctr 11 -> 10).
  - A second not-taken: lookup predicts not-taken, PredTarget = 0x44.
- Aliasing with ENTRIES = 16:
  - Allocate PC 0x40, then a taken update for 0x80 (same idx 0, different tag) with target 0x200.
  - Lookup 0x40 now misses (PredTarget = 0x44); lookup 0x80 hits with 0x200.
- Same-cycle hazard: in one cycle, look up PC 0x40 while updating 0x40 with taken, target 0x300. The lookup shows the old target that cycle and 0x300 the next cycle.
- Saturation with CNT_W = 4: after 20 updates that all mispredict, both BranchCount and MispredictCount read 15.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating counters and saturating performance counters.
// Latency: lookup and mispredict/redirect are combinational (0 cycles); table/counter updates are visible 1 cycle later.
// Backpressure: none; one update may be accepted every cycle and is never stalled.
//
// Ports:
//   Clk, Reset (async active-low)
//   LookupPC -> PredTaken / PredTarget        : IF-stage next-fetch prediction
//   Update*                                   : resolve-stage outcome write-back
//   Mispredict / CorrectPC                    : same-cycle flush and redirect address
//   BranchCount / MispredictCount             : saturating performance counters
module branch_target_predictor #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] LookupPC,
   output logic              PredTaken,
   output logic [ADDR_W-1:0] PredTarget,
   input  logic              UpdateValid,
   input  logic [ADDR_W-1:0] UpdatePC,
   input  logic              UpdateTaken,
   input  logic [ADDR_W-1:0] UpdateTarget,
   input  logic              UpdatePredTaken,
   input  logic [ADDR_W-1:0] UpdatePredTarget,
   output logic              Mispredict,
   output logic [ADDR_W-1:0] CorrectPC,
   output logic [CNT_W-1:0]  BranchCount,
   output logic [CNT_W-1:0]  MispredictCount
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Table state
   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [1:0]        ctr_d    [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic [ADDR_W-1:0] target_d [ENTRIES];

   logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

   // PC[1:0] never participates in index or tag
   logic [IDX_W-1:0]  lk_idx, up_idx;
   logic [TAG_W-1:0]  lk_tag, up_tag;
   logic              lk_hit, up_hit;

   assign lk_idx = LookupPC[IDX_W+1:2];
   assign lk_tag = LookupPC[ADDR_W-1:IDX_W+2];
   assign up_idx = UpdatePC[IDX_W+1:2];
   assign up_tag = UpdatePC[ADDR_W-1:IDX_W+2];

   // Lookup: reads only the registered table, so a same-cycle update is not seen
   always_comb begin
      lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      PredTaken  = lk_hit && ctr_q[lk_idx][1];
      PredTarget = PredTaken ? target_q[lk_idx] : LookupPC + ADDR_W'(4);
   end

   // Resolve-side outputs
   always_comb begin
      Mispredict = UpdateValid &&
                   ((UpdatePredTaken != UpdateTaken) ||
                    (UpdateTaken && (UpdatePredTarget != UpdateTarget)));
      CorrectPC  = UpdateTaken ? UpdateTarget : UpdatePC + ADDR_W'(4);
   end

   // Table next state
   always_comb begin
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      tag_d    = tag_q;
      target_d = target_q;
      up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      if (UpdateValid) begin
         if (up_hit) begin
            if (UpdateTaken) begin
               target_d[up_idx] = UpdateTarget;
               if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
            end else begin
               if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
            end
         end else if (UpdateTaken) begin
            // Taken miss replaces whatever lived at this index, starting weakly taken
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = UpdateTarget;
            ctr_d[up_idx]    = 2'b10;
         end
      end
   end

   // Performance counters stick at all-ones
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (UpdateValid && (branch_cnt_q != CNT_MAX)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (Mispredict && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         valid_q       <= valid_d;
         ctr_q         <= ctr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   // Tag and target are qualified by valid, so they need no reset
   always_ff @(posedge Clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign BranchCount     = branch_cnt_q;
   assign MispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (ENTRIES=16, ADDR_W=32, CNT_W=4).
// Directed scenarios followed by randomized traffic against a behavioural table model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after either edge.
module tb_branch_target_predictor;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] LookupPC;
   logic        PredTaken;
   logic [31:0] PredTarget;
   logic        UpdateValid;
   logic [31:0] UpdatePC;
   logic        UpdateTaken;
   logic [31:0] UpdateTarget;
   logic        UpdatePredTaken;
   logic [31:0] UpdatePredTarget;
   logic        Mispredict;
   logic [31:0] CorrectPC;
   logic [3:0]  BranchCount;
   logic [3:0]  MispredictCount;

   always #5 Clk = ~Clk;

   branch_target_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .LookupPC(LookupPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
      .UpdateValid(UpdateValid), .UpdatePC(UpdatePC), .UpdateTaken(UpdateTaken),
      .UpdateTarget(UpdateTarget), .UpdatePredTaken(UpdatePredTaken),
      .UpdatePredTarget(UpdatePredTarget), .Mispredict(Mispredict), .CorrectPC(CorrectPC),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Behavioural model: one record per index, full upper PC bits as the tag
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   int          m_bc, m_mc;
   logic [31:0] obs_tgt;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
   endtask

   task automatic model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
      int i = midx(pc);
      if (m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2) begin
         t = 1'b1; tgt = m_tgt[i];
      end else begin
         t = 1'b0; tgt = pc + 32'd4;
      end
   endtask

   // One clock: drive at the falling edge, check combinational outputs, then check counters after the edge
   task automatic cycle(input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit upt, input logic [31:0] uptgt, input logic [31:0] lpc);
      bit          et, emis, hit;
      logic [31:0] etg;
      int          i;
      @(negedge Clk);
      UpdateValid = uv; UpdatePC = upc; UpdateTaken = ut; UpdateTarget = utgt;
      UpdatePredTaken = upt; UpdatePredTarget = uptgt; LookupPC = lpc;
      #1;
      model_predict(lpc, et, etg);
      emis = uv && ((upt != ut) || (ut && uptgt != utgt));
      check("pred_taken", 32'(PredTaken), 32'(et));
      check("pred_target", PredTarget, etg);
      check("mispredict", 32'(Mispredict), 32'(emis));
      check("correct_pc", CorrectPC, ut ? utgt : upc + 32'd4);
      obs_tgt = PredTarget;
      @(posedge Clk);
      #1;
      if (uv) begin
         if (m_bc < 15) m_bc++;
         if (emis && m_mc < 15) m_mc++;
         i = midx(upc);
         hit = m_valid[i] && m_tag[i] == (upc >> 6);
         if (hit) begin
            if (ut) begin
               m_tgt[i] = utgt;
               if (m_ctr[i] < 3) m_ctr[i]++;
            end else if (m_ctr[i] > 0) begin
               m_ctr[i]--;
            end
         end else if (ut) begin
            m_valid[i] = 1'b1; m_tag[i] = upc >> 6; m_tgt[i] = utgt; m_ctr[i] = 2;
         end
      end
      check("branch_cnt", 32'(BranchCount), 32'(m_bc));
      check("mispred_cnt", 32'(MispredictCount), 32'(m_mc));
   endtask

   // Realistic update: predicted fields come from the model's view of the table
   task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      bit          pt;
      logic [31:0] ptg;
      model_predict(pc, pt, ptg);
      cycle(1'b1, pc, taken, tgt, pt, ptg, pc);
   endtask

   task automatic look(input logic [31:0] pc);
      LookupPC = pc; UpdateValid = 1'b0;
      #1;
   endtask

   // Asynchronous reset pulse in the middle of a cycle, released on a falling edge
   task automatic do_reset();
      @(negedge Clk);
      #2;
      UpdateValid = 1'b0;
      Reset = 1'b0;
      model_reset();
      #1;
      check("rst_pred_taken", 32'(PredTaken), 32'd0);
      check("rst_pred_target", PredTarget, LookupPC + 32'd4);
      check("rst_branch_cnt", 32'(BranchCount), 32'd0);
      check("rst_mispred_cnt", 32'(MispredictCount), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] base;
      base = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0;
      return base | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      bit          rpt;
      logic [31:0] rptg, upc;
      Reset = 1'b1;
      LookupPC = 32'h0; UpdateValid = 1'b0; UpdatePC = 32'h0; UpdateTaken = 1'b0;
      UpdateTarget = 32'h0; UpdatePredTaken = 1'b0; UpdatePredTarget = 32'h0;
      #1 Reset = 1'b0;
      model_reset();
      #11;
      check("init_pred_taken", 32'(PredTaken), 32'd0);
      check("init_pred_target", PredTarget, 32'h4);
      check("init_branch_cnt", 32'(BranchCount), 32'd0);
      check("init_mispred_cnt", 32'(MispredictCount), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;

      // Allocate and train
      cycle(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40);
      check("alloc_mispredict", 32'(Mispredict), 32'd1);
      check("alloc_correct_pc", CorrectPC, 32'h100);
      look(32'h40);
      check("alloc_taken", 32'(PredTaken), 32'd1);
      check("alloc_target", PredTarget, 32'h100);
      check("alloc_mispred_cnt", 32'(MispredictCount), 32'd1);

      // Hysteresis
      repeat (3) train(32'h40, 1'b1, 32'h100);
      train(32'h40, 1'b0, 32'h100);
      look(32'h40);
      check("hyst_still_taken", 32'(PredTaken), 32'd1);
      train(32'h40, 1'b0, 32'h100);
      look(32'h40);
      check("hyst_now_nt", 32'(PredTaken), 32'd0);
      check("hyst_nt_target", PredTarget, 32'h44);

      // Aliasing on index 0
      train(32'h80, 1'b1, 32'h200);
      look(32'h40);
      check("alias_old_miss", PredTarget, 32'h44);
      look(32'h80);
      check("alias_new_taken", 32'(PredTaken), 32'd1);
      check("alias_new_target", PredTarget, 32'h200);

      // Same-cycle lookup/update hazard on a resident entry
      train(32'h40, 1'b1, 32'h100);
      cycle(1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 32'h100, 32'h40);
      check("hazard_old", obs_tgt, 32'h100);
      look(32'h40);
      check("hazard_new", PredTarget, 32'h300);

      // Reset after allocations
      do_reset();
      #1;
      check("post_rst_taken", 32'(PredTaken), 32'd0);
      check("post_rst_target", PredTarget, 32'h44);

      // Counter saturation: 20 mispredicting updates
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 32'h1000 + 32'(i) * 32'd4, 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0);
      check("sat_branch_cnt", 32'(BranchCount), 32'd15);
      check("sat_mispred_cnt", 32'(MispredictCount), 32'd15);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if (n % 60 == 59) do_reset();
         upc = rand_pc();
         if ($urandom_range(0, 1) == 1) begin
            model_predict(upc, rpt, rptg);
         end else begin
            rpt  = 1'($urandom_range(0, 1));
            rptg = $urandom_range(0, 7) << 4;
         end
         cycle($urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) << 4, rpt, rptg,
               ($urandom_range(0, 3) == 0) ? upc : rand_pc());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
